// File: rtl/relu_maxpool_pkg.sv
// rtl/relu_maxpool_pkg.sv - shared constants and requantisation helper for the relu/maxpool stage
package conv_pkg;

    localparam int DEF_SUM_BW  = 16;
    localparam int DEF_DATA_BW = 8;
    localparam int DEF_IN_W    = 28;
    localparam int DEF_IN_H    = 28;

    localparam int SAT_MAX = 2 ** (DEF_DATA_BW - 1) - 1;
    localparam int COL_BW  = $clog2(DEF_IN_W);
    localparam int ROW_BW  = $clog2(DEF_IN_H);
    localparam int POOL_W  = DEF_IN_W / 2;

    // ReLU followed by saturation to the largest positive DATA_BW value.
    function automatic logic signed [31:0] sat_relu(input logic signed [31:0] s,
                                                    input int data_bw = DEF_DATA_BW);
        logic signed [31:0] sat_max;
        sat_max = (32'sd1 <<< (data_bw - 1)) - 32'sd1;
        if (s < 0) begin
            return '0;
        end
        if (s > sat_max) begin
            return sat_max;
        end
        return s;
    endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// rtl/relu_maxpool_if.sv - sample-in / pooled-out signal bundle for the relu/maxpool stage
interface relu_maxpool_if #(
    parameter int SUM_BW  = 16,
    parameter int DATA_BW = 8
);
    logic signed [SUM_BW-1:0]  i_y;
    logic                      i_valid;
    logic                      i_clear;
    logic signed [DATA_BW-1:0] o_x;
    logic                      o_valid;
    logic                      o_frame_done;

    modport master (
        output i_y, i_valid, i_clear,
        input  o_x, o_valid, o_frame_done
    );

    modport slave (
        input  i_y, i_valid, i_clear,
        output o_x, o_valid, o_frame_done
    );
endinterface

// File: rtl/relu_maxpool_pool_line_buffer.sv
// rtl/relu_maxpool_pool_line_buffer.sv - one-row store of horizontal maxima between even and odd rows
module pool_line_buffer #(
    parameter int DEPTH   = 14,
    parameter int DATA_BW = 8,
    parameter int AW      = 4
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [DATA_BW-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [DATA_BW-1:0] rdata_o
);

    // Contents are never reset: every even row writes an entry before the odd row reads it.
    logic [DATA_BW-1:0] mem_q [DEPTH];

    // Write port: store the horizontal max of an even-row pair.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/relu_maxpool.sv
// rtl/relu_maxpool.sv - requantise, ReLU/saturate and 2x2 stride-2 max-pool a raster sample stream
module relu_maxpool
    import conv_pkg::*;
#(
    parameter int SUM_BW  = 16,
    parameter int DATA_BW = 8,
    parameter int IN_W    = 28,
    parameter int IN_H    = 28,
    parameter int SHIFT   = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    relu_maxpool_if.slave  bus
);

    localparam int  CBW   = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int  RBW   = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int  PW    = IN_W / 2;
    localparam int  PH    = IN_H / 2;
    localparam int  LB_D  = (PW > 0) ? PW : 1;
    localparam int  LB_AW = (PW > 1) ? $clog2(PW) : 1;
    localparam bit  H_ODD = (IN_H % 2) == 1;

    logic [CBW-1:0]            col_q, col_d;
    logic [RBW-1:0]            row_q, row_d;
    logic signed [DATA_BW-1:0] h_q, h_d;
    logic signed [DATA_BW-1:0] o_x_q, o_x_d;
    logic                      o_valid_q, o_valid_d;
    logic                      fd_q, fd_d;

    logic signed [SUM_BW-1:0]  s_sh;
    logic signed [DATA_BW-1:0] q, hmax, vmax, lb_rd;
    logic [DATA_BW-1:0]        lb_rdata;
    logic                      accept, last_col, last_row, col_odd, row_odd;
    logic                      in_pool, out_fire, lb_we;
    logic [LB_AW-1:0]          lb_addr;

    // Datapath: requantise the incoming sample and form horizontal/vertical maxima.
    always_comb begin
        s_sh     = bus.i_y >>> SHIFT;
        q        = DATA_BW'(sat_relu(32'(s_sh), DATA_BW));
        accept   = bus.i_valid && !bus.i_clear;
        last_col = (32'(col_q) == IN_W - 1);
        last_row = (32'(row_q) == IN_H - 1);
        col_odd  = col_q[0];
        row_odd  = row_q[0];
        // Trailing column/row of an odd-sized map is consumed but never pooled.
        in_pool  = (32'(col_q) < 2 * PW) && (32'(row_q) < 2 * PH);
        lb_addr  = LB_AW'(col_q >> 1);
        lb_rd    = lb_rdata;
        hmax     = (q > h_q) ? q : h_q;
        vmax     = (lb_rd > hmax) ? lb_rd : hmax;
        out_fire = accept && col_odd && row_odd && in_pool;
        lb_we    = accept && col_odd && !row_odd && in_pool;
    end

    // Next-state: counters advance per accepted sample; outputs are single-cycle pulses.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        h_d       = h_q;
        o_x_d     = '0;
        o_valid_d = 1'b0;
        fd_d      = 1'b0;
        if (bus.i_clear) begin
            col_d = '0;
            row_d = '0;
        end else if (bus.i_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RBW'(1);
            end else begin
                col_d = col_q + CBW'(1);
            end
            if (!col_odd) begin
                h_d = q;
            end
            if (out_fire) begin
                o_x_d     = vmax;
                o_valid_d = 1'b1;
            end
            if (H_ODD) begin
                fd_d = last_col && last_row;
            end else begin
                fd_d = out_fire && last_row && (32'(col_q) == 2 * PW - 1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            h_q       <= '0;
            o_x_q     <= '0;
            o_valid_q <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            h_q       <= h_d;
            o_x_q     <= o_x_d;
            o_valid_q <= o_valid_d;
            fd_q      <= fd_d;
        end
    end

    pool_line_buffer #(
        .DEPTH   (LB_D),
        .DATA_BW (DATA_BW),
        .AW      (LB_AW)
    ) u_lb (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (hmax),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    assign bus.o_x          = o_x_q;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_frame_done = fd_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb/tb_relu_maxpool.sv - directed self-checking bench for relu_maxpool
module tb_relu_maxpool;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    relu_maxpool_if #(.SUM_BW(16), .DATA_BW(8)) ifa ();
    relu_maxpool_if #(.SUM_BW(16), .DATA_BW(8)) ifb ();
    relu_maxpool_if #(.SUM_BW(16), .DATA_BW(8)) ifc ();

    relu_maxpool #(.SUM_BW(16), .DATA_BW(8), .IN_W(4), .IN_H(4), .SHIFT(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    relu_maxpool #(.SUM_BW(16), .DATA_BW(8), .IN_W(4), .IN_H(4), .SHIFT(2))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    relu_maxpool #(.SUM_BW(16), .DATA_BW(8), .IN_W(5), .IN_H(5), .SHIFT(0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tags follow each sample so outputs can be tied to the input that produced them.
    int tag_a = 0, tag_b = 0, tag_c = 0;
    int ptag_a = -1, ptag_b = -1, ptag_c = -1;
    always @(posedge clk) begin
        ptag_a <= (ifa.i_valid && !ifa.i_clear) ? tag_a : -1;
        ptag_b <= (ifb.i_valid && !ifb.i_clear) ? tag_b : -1;
        ptag_c <= (ifc.i_valid && !ifc.i_clear) ? tag_c : -1;
    end

    int va[$], ta[$], fta[$], fva[$];
    int vb[$];
    int vc[$], ftc[$], fvc[$];
    int zviol = 0;
    int orphan = 0;

    always @(negedge clk) begin
        if (ifa.o_valid) begin
            va.push_back(int'(ifa.o_x));
            ta.push_back(ptag_a);
            if (ptag_a < 0) orphan++;
        end else if (ifa.o_x !== 8'sd0) zviol++;
        if (ifa.o_frame_done) begin
            fta.push_back(ptag_a);
            fva.push_back(int'(ifa.o_valid));
        end
        if (ifb.o_valid) vb.push_back(int'(ifb.o_x));
        else if (ifb.o_x !== 8'sd0) zviol++;
        if (ifc.o_valid) vc.push_back(int'(ifc.o_x));
        else if (ifc.o_x !== 8'sd0) zviol++;
        if (ifc.o_frame_done) begin
            ftc.push_back(ptag_c);
            fvc.push_back(int'(ifc.o_valid));
        end
    end

    task automatic flush();
        va.delete(); ta.delete(); fta.delete(); fva.delete();
        vb.delete(); vc.delete(); ftc.delete(); fvc.delete();
    endtask

    task automatic drv(input int d, input int y, input bit v, input bit c);
        @(posedge clk);
        #1;
        case (d)
            0: begin ifa.i_y = 16'(y); ifa.i_valid = v; ifa.i_clear = c; tag_a = y; end
            1: begin ifb.i_y = 16'(y); ifb.i_valid = v; ifb.i_clear = c; tag_b = y; end
            default: begin ifc.i_y = 16'(y); ifc.i_valid = v; ifc.i_clear = c; tag_c = y; end
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 0, 1'b0, 1'b0);
            drv(1, 0, 1'b0, 1'b0);
            drv(2, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_seq(input string tag, input int got[$], input int e[$]);
        chk({tag, "_count"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -999, e[i]);
        end
    endtask

    int exp4[$];
    int exp8[$];
    int exp_lat[$];

    initial begin
        ifa.i_y = '0; ifa.i_valid = 1'b0; ifa.i_clear = 1'b0;
        ifb.i_y = '0; ifb.i_valid = 1'b0; ifb.i_clear = 1'b0;
        ifc.i_y = '0; ifc.i_valid = 1'b0; ifc.i_clear = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_x", int'(ifa.o_x), 0);
        chk("rst_o_valid", int'(ifa.o_valid), 0);
        chk("rst_frame_done", int'(ifa.o_frame_done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        flush();

        // Scenario 1: ramp 0..15 on a 4x4 map.
        for (int i = 0; i < 16; i++) drv(0, i, 1'b1, 1'b0);
        idle(2);
        exp4 = '{5, 7, 13, 15};
        chk_seq("t1_val", va, exp4);
        exp_lat = '{5, 7, 13, 15};
        chk_seq("t1_lat", ta, exp_lat);
        chk("t1_fd_count", fta.size(), 1);
        chk("t1_fd_tag", (fta.size() > 0) ? fta[0] : -1, 15);
        chk("t1_fd_with_valid", (fva.size() > 0) ? fva[0] : -1, 1);
        flush();

        // Scenario 2: all-negative frame then saturating frame, back to back.
        for (int i = 0; i < 16; i++) drv(0, -5, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) drv(0, 300, 1'b1, 1'b0);
        idle(2);
        exp8 = '{0, 0, 0, 0, 127, 127, 127, 127};
        chk_seq("t2_val", va, exp8);
        chk("t2_fd_count", fta.size(), 2);
        flush();

        // Scenario 3: shift by 2, single large value at (1,1), -1 elsewhere.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                drv(1, (r == 1 && c == 1) ? 300 : -1, 1'b1, 1'b0);
        idle(2);
        exp4 = '{75, 0, 0, 0};
        chk_seq("t3_val", vb, exp4);
        flush();

        // Scenario 4: ramp with roughly 30% idle cycles.
        orphan = 0;
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(0, 99) < 30) drv(0, 0, 1'b0, 1'b0);
            drv(0, i, 1'b1, 1'b0);
        end
        idle(2);
        exp4 = '{5, 7, 13, 15};
        chk_seq("t4_val", va, exp4);
        chk_seq("t4_lat", ta, exp_lat);
        chk("t4_orphan_valid", orphan, 0);
        flush();

        // Scenario 5a: reset mid-frame, then a full frame.
        for (int i = 0; i < 6; i++) drv(0, i, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        ifa.i_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t5_rst_valid", int'(ifa.o_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        flush();
        for (int i = 0; i < 16; i++) drv(0, i, 1'b1, 1'b0);
        idle(2);
        exp4 = '{5, 7, 13, 15};
        chk_seq("t5_rst_val", va, exp4);
        flush();

        // Scenario 5b: clear together with a valid sample that must be dropped.
        for (int i = 0; i < 6; i++) drv(0, i, 1'b1, 1'b0);
        drv(0, 99, 1'b1, 1'b1);
        drv(0, 0, 1'b1, 1'b0);
        chk("t5_clr_valid", int'(ifa.o_valid), 0);
        flush();
        for (int i = 1; i < 16; i++) drv(0, i, 1'b1, 1'b0);
        idle(2);
        chk_seq("t5_clr_val", va, exp4);
        flush();

        // Scenario 6: 5x5 map, two frames back to back.
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 25; i++) drv(2, i, 1'b1, 1'b0);
        idle(3);
        exp8 = '{6, 8, 16, 18, 6, 8, 16, 18};
        chk_seq("t6_val", vc, exp8);
        chk("t6_fd_count", ftc.size(), 2);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t6_fd_tag[%0d]", k), (k < ftc.size()) ? ftc[k] : -1, 24);
            chk($sformatf("t6_fd_valid[%0d]", k), (k < fvc.size()) ? fvc[k] : -1, 0);
        end

        chk("zero_when_idle", zviol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
